// File: rtl/vecmac_seq_ctrl.sv
// Job sequencer for the 8-lane INT8 dot-product engine: streams a job's operand
// beats into the engine and accumulates its partial sums into one wide result.
module vecmac_seq_ctrl #(
  parameter int BUSW  = 64,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BUSW-1:0]      s_a,
  input  logic [BUSW-1:0]      s_b,
  output logic                 eng_in_valid,
  output logic [BUSW-1:0]      eng_in_a,
  output logic [BUSW-1:0]      eng_in_b,
  input  logic                 eng_out_valid,
  input  logic [18:0]          eng_out_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [LEN_W+18:0]    res_sum,
  output logic                 busy,
  output logic                 err_unexp
);

  localparam int ACC_W = LEN_W + 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   returned;
  logic [ACC_W-1:0]   acc;

  logic               acc_hit;
  logic [LEN_W-1:0]   ret_next;
  logic [ACC_W-1:0]   acc_next;

  // A result only counts if a beat is still outstanding; anything else is spurious.
  always_comb begin
    acc_hit  = eng_out_valid && (returned < issued);
    ret_next = returned;
    acc_next = acc;
    if (acc_hit) begin
      ret_next = returned + 1'b1;
      acc_next = acc + ACC_W'(eng_out_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      issued       <= '0;
      returned     <= '0;
      acc          <= '0;
      cmd_ready    <= 1'b0;
      s_ready      <= 1'b0;
      eng_in_valid <= 1'b0;
      eng_in_a     <= '0;
      eng_in_b     <= '0;
      res_valid    <= 1'b0;
      res_sum      <= '0;
      busy         <= 1'b0;
      err_unexp    <= 1'b0;
    end else begin
      eng_in_valid <= 1'b0;
      err_unexp    <= 1'b0;

      if (eng_out_valid) begin
        if (acc_hit) begin
          acc      <= acc_next;
          returned <= ret_next;
        end else begin
          err_unexp <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            len_q     <= cmd_len;
            issued    <= '0;
            returned  <= '0;
            acc       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_sum   <= '0;
            end else begin
              state   <= FEED;
              s_ready <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        FEED: begin
          if (s_valid && s_ready) begin
            eng_in_a     <= s_a;
            eng_in_b     <= s_b;
            eng_in_valid <= 1'b1;
            issued       <= issued + 1'b1;
            if (issued == len_q - 1'b1) begin
              state   <= DRAIN;
              s_ready <= 1'b0;
            end
          end
        end

        // Looks at the post-edge count so the final sum is published one cycle later.
        DRAIN: begin
          if (ret_next == len_q) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_sum   <= acc_next;
          end
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vecmac_seq_ctrl.sv
// Randomized bench for vecmac_seq_ctrl with a latency-8 engine model; job results
// are predicted from the accepted beats as plain sums of byte products.
module tb_vecmac_seq_ctrl;

  localparam int L = 8;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_a;
  logic [63:0] s_b;
  logic        eng_in_valid;
  logic [63:0] eng_in_a;
  logic [63:0] eng_in_b;
  logic        eng_out_valid;
  logic [18:0] eng_out_sum;
  logic        res_valid;
  logic        res_ready;
  logic [34:0] res_sum;
  logic        busy;
  logic        err_unexp;

  logic        inj_valid;
  logic [18:0] inj_sum;
  logic        pv [L];
  logic [18:0] ps [L];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastOutCyc = 0;
  int riseCyc = 0;
  int inPulses = 0;
  int errPulses = 0;
  logic resPrev = 1'b0;

  vecmac_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .eng_in_valid(eng_in_valid), .eng_in_a(eng_in_a), .eng_in_b(eng_in_b),
    .eng_out_valid(eng_out_valid), .eng_out_sum(eng_out_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .busy(busy), .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint dotBytes(input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    for (int i = 0; i < 8; i++) s += longint'(a[8*i +: 8]) * longint'(b[8*i +: 8]);
    return s;
  endfunction

  // Engine stand-in: fixed-latency pipeline, plus an injection port for spurious results.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        ps[i] <= '0;
      end
    end else begin
      pv[0] <= eng_in_valid;
      ps[0] <= 19'(dotBytes(eng_in_a, eng_in_b));
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end

  assign eng_out_valid = pv[L-1] | inj_valid;
  assign eng_out_sum   = inj_valid ? inj_sum : ps[L-1];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (eng_out_valid) lastOutCyc = cyc;
    if (res_valid && !resPrev) riseCyc = cyc;
    resPrev = res_valid;
    if (eng_in_valid) inPulses++;
    if (err_unexp) errPulses++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void pickBeat(input int mode, output logic [63:0] a, output logic [63:0] b);
    case (mode)
      0: begin a = '1; b = '1; end
      1: begin a = 64'h0101_0101_0101_0101; b = 64'h0202_0202_0202_0202; end
      3: begin a = 64'h0101_0101_0101_0101; b = 64'h0101_0101_0101_0101; end
      default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
    endcase
  endfunction

  // Drives one cycle of source traffic; reports whether this cycle hands over a beat.
  task automatic applyStimulus(input int mode, input int gap_pct, output logic hs,
                               output longint prod);
    logic [63:0] a, b;
    pickBeat(mode, a, b);
    if ($urandom_range(99) < gap_pct) begin
      s_valid = 1'b0;
    end else begin
      s_valid = 1'b1;
      s_a = a;
      s_b = b;
    end
    hs = s_valid && s_ready;
    prod = dotBytes(a, b);
    @(negedge clk);
  endtask

  task automatic runJob(input int len, input int mode, input int gap_pct, input int stall,
                        output longint got);
    longint expSum = 0;
    longint prod;
    int sent = 0;
    int guard = 0;
    int waitCyc = 0;
    logic hs;
    logic [34:0] held;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    inPulses = 0;
    errPulses = 0;
    cmd_valid = 1'b1;
    cmd_len = 16'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("busy_after_cmd", busy, 1);
    while (sent < len && guard < len * 4 + 100) begin
      applyStimulus(mode, gap_pct, hs, prod);
      if (hs) begin
        expSum += prod;
        sent++;
      end
      guard++;
    end
    s_valid = 1'b0;
    checkOutput("beats_sent", sent, len);
    while (!res_valid && waitCyc < 100) begin
      checkOutput("cmd_ready_busy", cmd_ready, 0);
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("res_valid", res_valid, 1);
    checkOutput("res_sum", res_sum, expSum);
    checkOutput("in_pulses", inPulses, len);
    checkOutput("no_err_pulse", errPulses, 0);
    if (len > 0) checkOutput("res_latency", riseCyc - lastOutCyc, 1);
    else checkOutput("zero_len_latency", waitCyc, 0);
    got = longint'(res_sum);
    held = res_sum;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_res_valid", res_valid, 1);
      checkOutput("stall_res_sum", res_sum, held);
      checkOutput("stall_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("res_valid_clear", res_valid, 0);
    checkOutput("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    longint got;
    logic hs;
    longint prod;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_len = '0;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    res_ready = 1'b0;
    inj_valid = 1'b0;
    inj_sum = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_eng_in_valid", eng_in_valid, 0);
    checkOutput("rst_eng_in_a", eng_in_a, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_sum", res_sum, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_unexp, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_cmd_ready", cmd_ready, 1);
    checkOutput("post_rst_busy", busy, 0);

    runJob(1, 0, 0, 0, got);
    checkOutput("single_beat_value", got, 520200);

    runJob(0, 2, 0, 0, got);
    checkOutput("zero_len_value", got, 0);

    runJob(4, 1, 40, 5, got);
    checkOutput("bubbles_value", got, 64);

    errPulses = 0;
    inj_valid = 1'b1;
    inj_sum = 19'd100;
    @(negedge clk);
    inj_valid = 1'b0;
    checkOutput("spurious_pulse", err_unexp, 1);
    @(negedge clk);
    checkOutput("spurious_one_cycle", err_unexp, 0);
    checkOutput("spurious_count", errPulses, 1);
    checkOutput("spurious_idle", busy, 0);
    runJob(1, 3, 0, 0, got);
    checkOutput("after_spurious_value", got, 8);

    for (int j = 0; j < 6; j++) begin
      runJob($urandom_range(20, 1), 2, $urandom_range(50), $urandom_range(3), got);
    end

    // Mid-job reset while results are still draining through the engine.
    cmd_valid = 1'b1;
    cmd_len = 16'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(2, 0, hs, prod);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("drain_s_ready", s_ready, 0);
    checkOutput("drain_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_cmd_ready", cmd_ready, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_s_ready", s_ready, 0);
    checkOutput("async_res_valid", res_valid, 0);
    checkOutput("async_eng_in_a", eng_in_a, 0);
    checkOutput("async_eng_in_b", eng_in_b, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    runJob(2, 2, 0, 1, got);

    runJob(65535, 0, 0, 0, got);
    checkOutput("full_len_value", got, 64'd34091307000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
